// File: rtl/currctrl_debug_trace_ram.sv
// rtl/currctrl_debug_trace_ram.sv - decimated circular debug trace buffer with pre/post trigger split and Avalon-MM host access
module currctrl_debug_trace_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int DECIM_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              trig_in,
    input  logic [ADDR_W:0]   address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    output logic              irq
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] HALF_L  = (ADDR_W + 1)'(DEPTH / 2);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);
    localparam logic [DECIM_W-1:0] DEC_ONE = (DECIM_W)'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_trig_ptr;
    logic [ADDR_W:0]    r_post_count;
    logic [ADDR_W:0]    r_pre_cnt;
    logic [ADDR_W:0]    r_post_cnt;
    logic [DECIM_W-1:0] r_decim;
    logic [DECIM_W-1:0] r_dec_cnt;
    logic               r_trig_q;
    logic               r_triggered;
    logic               r_prefill_done;

    logic               w_csr_sel;
    logic               w_rd_acc;
    logic               w_wr_ctrl;
    logic               w_arm;
    logic               w_abort;
    logic               w_force;
    logic               w_cfg_ok;
    logic               w_arm_go;
    logic               w_capturing;
    logic               w_store;
    logic               w_trig_rise;
    logic               w_enter_post;
    logic               w_enter_wait;
    logic [ADDR_W:0]    w_pre_target;
    logic [ADDR_W:0]    w_post_new;
    logic [31:0]        w_csr_rdata;
    logic [31:0]        w_buf_rdata;

    assign w_csr_sel    = chipselect & ~address[ADDR_W];
    assign w_rd_acc     = chipselect & read;
    assign w_wr_ctrl    = w_csr_sel & write & (address[1:0] == 2'd0);
    assign w_arm        = w_wr_ctrl & writedata[0];
    assign w_abort      = w_wr_ctrl & writedata[1];
    assign w_force      = w_wr_ctrl & writedata[2];
    assign w_cfg_ok     = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_arm_go     = w_cfg_ok & w_arm & ~w_abort;
    assign w_capturing  = (r_state == ST_ARMED) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST);
    assign w_store      = w_capturing & sample_valid & (r_dec_cnt == '0);
    assign w_trig_rise  = trig_in & ~r_trig_q;
    assign w_pre_target = DEPTH_L - r_post_count;
    assign w_enter_post = (w_next == ST_POST) && (r_state != ST_POST);
    assign w_enter_wait = (r_state == ST_ARMED) && (w_next == ST_WAIT_TRIG);
    assign irq          = (r_state == ST_DONE);

    // Clamp a host POST_COUNT write into the legal range 1..DEPTH
    always_comb begin
        w_post_new = writedata[ADDR_W:0];
        if (writedata == 32'd0) begin
            w_post_new = ONE_L;
        end else if (writedata > 32'(DEPTH)) begin
            w_post_new = DEPTH_L;
        end
    end

    // Capture FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ABORT overrides every other request.
    // ARM together with FORCE_TRIG from IDLE/DONE starts straight in POST
    // so a full post-only capture begins at address 0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm) begin
                    w_next = w_force ? ST_POST : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_force) begin
                    w_next = ST_POST;
                end else if (w_pre_target == '0) begin
                    w_next = ST_WAIT_TRIG;
                end else if (w_store && ((r_pre_cnt + ONE_L) == w_pre_target)) begin
                    w_next = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (w_trig_rise || w_force) begin
                    w_next = ST_POST;
                end
            end
            ST_POST: begin
                if (w_store && ((r_post_cnt + ONE_L) == r_post_count)) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    // Host-programmable configuration, frozen while a capture is running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_post_count <= HALF_L;
            r_decim      <= '0;
        end else if (w_csr_sel && write && w_cfg_ok) begin
            if (address[1:0] == 2'd1) begin
                r_post_count <= w_post_new;
            end else if (address[1:0] == 2'd2) begin
                r_decim <= writedata[DECIM_W-1:0];
            end
        end
    end

    // Write pointer, prefill/post counters, decimator and trigger bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_trig_ptr     <= '0;
            r_pre_cnt      <= '0;
            r_post_cnt     <= '0;
            r_dec_cnt      <= '0;
            r_trig_q       <= 1'b0;
            r_triggered    <= 1'b0;
            r_prefill_done <= 1'b0;
        end else begin
            r_trig_q <= trig_in;
            if (w_arm_go) begin
                r_wr_ptr       <= '0;
                r_pre_cnt      <= '0;
                r_post_cnt     <= '0;
                r_dec_cnt      <= '0;
                r_prefill_done <= 1'b0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    if (r_state == ST_ARMED) begin
                        r_pre_cnt <= r_pre_cnt + ONE_L;
                    end
                    if (r_state == ST_POST) begin
                        r_post_cnt <= r_post_cnt + ONE_L;
                        if (r_post_cnt == '0) begin
                            r_trig_ptr <= r_wr_ptr;
                        end
                    end
                end
                if (w_capturing && sample_valid) begin
                    r_dec_cnt <= (r_dec_cnt == '0) ? r_decim : (r_dec_cnt - DEC_ONE);
                end
                if (w_enter_wait) begin
                    r_prefill_done <= 1'b1;
                end
            end
            if (w_enter_post) begin
                r_triggered <= 1'b1;
            end else if (w_arm_go) begin
                r_triggered <= 1'b0;
            end
        end
    end

    // Sample storage; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= sample_data;
        end
    end

    // CSR readback mux; unused low address bits alias
    always_comb begin
        w_csr_rdata = '0;
        case (address[1:0])
            2'd0: begin
                w_csr_rdata[2:0] = r_state;
                w_csr_rdata[4]   = r_triggered;
                w_csr_rdata[5]   = r_prefill_done;
            end
            2'd1: w_csr_rdata[ADDR_W:0]  = r_post_count;
            2'd2: w_csr_rdata[DECIM_W-1:0] = r_decim;
            default: begin
                w_csr_rdata[ADDR_W-1:0]     = r_trig_ptr;
                w_csr_rdata[16+ADDR_W-1:16] = r_wr_ptr;
            end
        endcase
    end

    // Buffer word, zero-extended to the bus width
    always_comb begin
        w_buf_rdata = '0;
        w_buf_rdata[DATA_W-1:0] = r_mem[address[ADDR_W-1:0]];
    end

    // Registered read port: fixed one-cycle latency, old data on same-cycle write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= w_rd_acc;
            if (w_rd_acc) begin
                readdata <= address[ADDR_W] ? w_buf_rdata : w_csr_rdata;
            end
        end
    end

endmodule

// File: tb/tb_currctrl_debug_trace_ram.sv
// tb/tb_currctrl_debug_trace_ram.sv - randomized self-checking bench for currctrl_debug_trace_ram
module tb_currctrl_debug_trace_ram;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int DECIM_W = 16;
    localparam int DEPTH   = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = '0;
    logic        trig_in = 1'b0;
    logic [9:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_state = 0;
    int          m_pc = 256;
    int          m_decim = 0;
    int          m_wr = 0;
    int          m_trig = 0;
    int          m_pre = 0;
    int          m_post = 0;
    int          m_idx = 0;
    bit          m_trg = 0;
    bit          m_pdone = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [DEPTH];

    currctrl_debug_trace_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DECIM_W(DECIM_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trig_in      (trig_in),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return 32'(m_state) | (32'(m_trg) << 4) | (32'(m_pdone) << 5);
    endfunction

    function automatic logic [31:0] m_ptrs();
        return (32'(m_wr) << 16) | 32'(m_trig);
    endfunction

    task automatic model_sample(input logic [31:0] v);
        if (m_state >= 1 && m_state <= 3) begin
            if (m_idx % (m_decim + 1) == 0) begin
                m_mem[m_wr]   = v;
                m_valid[m_wr] = 1'b1;
                if (m_state == 3 && m_post == 0) m_trig = m_wr;
                m_wr = (m_wr + 1) % DEPTH;
                if (m_state == 1) begin
                    m_pre++;
                    if (m_pre == DEPTH - m_pc) begin
                        m_state = 2;
                        m_pdone = 1'b1;
                    end
                end else if (m_state == 3) begin
                    m_post++;
                    if (m_post == m_pc) m_state = 4;
                end
            end
            m_idx++;
        end
    endtask

    task automatic csr_write(input int a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 10'(a & 3);
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        if (a == 0) begin
            if (d[1]) begin
                m_state = 0;
            end else if (m_state == 0 || m_state == 4) begin
                if (d[0]) begin
                    m_wr = 0; m_pre = 0; m_post = 0; m_idx = 0; m_pdone = 1'b0; m_trg = 1'b0;
                    if (d[2]) begin
                        m_state = 3;
                        m_trg   = 1'b1;
                    end else begin
                        m_state = 1;
                    end
                end
            end else if ((m_state == 1 || m_state == 2) && d[2]) begin
                m_state = 3;
                m_trg   = 1'b1;
            end
        end else if ((a == 1 || a == 2) && (m_state == 0 || m_state == 4)) begin
            if (a == 1) m_pc = (d == 0) ? 1 : ((d > DEPTH) ? DEPTH : int'(d));
            else        m_decim = int'(d[15:0]);
        end
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        check("readdatavalid", 32'(readdatavalid), 32'd1);
        d = readdata;
    endtask

    task automatic check_csr(input string tag, input int a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(10'(a & 3), d);
        check(tag, d, exp);
    endtask

    task automatic check_buf(input int a);
        logic [31:0] d;
        bus_read(10'(DEPTH + a), d);
        if (m_valid[a]) check($sformatf("buf[%0d]", a), d, m_mem[a]);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                sample_valid = 1'b0;
            end
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = $urandom;
            model_sample(sample_data);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic trig_pulse();
        @(negedge clk);
        trig_in = 1'b1;
        if (m_state == 2) begin
            m_state = 3;
            m_trg   = 1'b1;
        end
        @(negedge clk);
        trig_in = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int r;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("irq_in_reset", 32'(irq), 32'd0);
        check("rdv_in_reset", 32'(readdatavalid), 32'd0);
        reset_n = 1'b1;
        check_csr("status_reset", 0, 32'd0);
        check_csr("postcount_reset", 1, 32'd256);
        check_csr("decim_reset", 2, 32'd0);
        check_csr("ptrs_reset", 3, 32'd0);

        // POST_COUNT clamping and DECIM readback
        csr_write(1, 32'd0);
        check_csr("postcount_clamp0", 1, 32'd1);
        csr_write(1, 32'd1000);
        check_csr("postcount_clamp_hi", 1, 32'd512);
        r = $urandom_range(1, DEPTH);
        csr_write(1, 32'(r));
        check_csr("postcount_rand", 1, 32'(m_pc));
        r = $urandom_range(0, 65535);
        csr_write(2, 32'(r) | 32'h00AB_0000);
        check_csr("decim_rand", 2, 32'(m_decim));

        // basic capture: 4 post samples, trigger after 601 samples
        csr_write(2, 32'd0);
        csr_write(1, 32'd4);
        csr_write(0, 32'd1);
        check_csr("status_armed", 0, m_status());
        feed(601);
        check_csr("status_wait", 0, m_status());
        check_csr("ptrs_live", 3, m_ptrs());
        csr_write(1, 32'd77);
        check_csr("postcount_locked", 1, 32'd4);
        csr_write(0, 32'd1);
        check_csr("arm_ignored_wait", 0, m_status());
        trig_pulse();
        check_csr("status_post", 0, m_status());
        feed(4);
        check_csr("status_done", 0, m_status());
        check("irq_done", 32'(irq), 32'd1);
        check_csr("ptrs_done", 3, m_ptrs());
        feed(3);
        check_csr("ptrs_frozen", 3, m_ptrs());
        for (int a = 0; a < DEPTH; a++) check_buf(a);

        // back-to-back buffer reads
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 10'h200;
        @(negedge clk);
        address = 10'h201;
        check("b2b_rdv0", 32'(readdatavalid), 32'd1);
        check("b2b_data0", readdata, m_mem[0]);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        check("b2b_rdv1", 32'(readdatavalid), 32'd1);
        check("b2b_data1", readdata, m_mem[1]);
        @(negedge clk);
        check("b2b_rdv_off", 32'(readdatavalid), 32'd0);

        // decimation, post-only forced capture
        csr_write(2, 32'd2);
        csr_write(1, 32'd1000);
        check_csr("postcount_full", 1, 32'd512);
        csr_write(0, 32'd5);
        check_csr("status_forced", 0, m_status());
        feed(3 * DEPTH);
        check_csr("status_decim_done", 0, m_status());
        check("irq_decim", 32'(irq), 32'd1);
        check_csr("ptrs_decim", 3, m_ptrs());
        check_buf(0);
        check_buf(DEPTH - 1);
        for (int i = 0; i < 24; i++) check_buf($urandom_range(0, DEPTH - 1));

        // prefill guard: early edge and held level must not trigger
        csr_write(2, 32'd0);
        csr_write(1, 32'd256);
        csr_write(0, 32'd1);
        feed(10);
        @(negedge clk);
        trig_in = 1'b1;
        @(negedge clk);
        check_csr("guard_armed", 0, m_status());
        feed(246);
        repeat (3) @(negedge clk);
        check_csr("guard_level_wait", 0, m_status());
        @(negedge clk);
        trig_in = 1'b0;
        trig_pulse();
        check_csr("guard_post", 0, m_status());
        feed(256);
        check_csr("guard_done", 0, m_status());
        check_csr("guard_ptrs", 3, m_ptrs());
        for (int i = 0; i < 16; i++) check_buf($urandom_range(0, DEPTH - 1));

        // ARM|ABORT together, then abort mid-capture
        csr_write(0, 32'd3);
        check_csr("armabort_idle", 0, m_status());
        check("armabort_irq", 32'(irq), 32'd0);
        csr_write(0, 32'd1);
        feed(5);
        csr_write(0, 32'd2);
        check_csr("abort_idle", 0, m_status());
        check("abort_irq", 32'(irq), 32'd0);
        feed(4);
        for (int a = 0; a < 6; a++) check_buf(a);
        check_buf(300);

        // reset asserted mid-POST
        csr_write(1, 32'd100);
        csr_write(0, 32'd5);
        feed(10);
        check_csr("status_midpost", 0, m_status());
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("irq_reset_post", 32'(irq), 32'd0);
        check("rdv_reset_post", 32'(readdatavalid), 32'd0);
        reset_n = 1'b1;
        m_state = 0; m_pc = 256; m_decim = 0; m_trg = 1'b0; m_pdone = 1'b0; m_wr = 0; m_trig = 0;
        check_csr("status_after_reset", 0, 32'd0);
        check_csr("postcount_after_reset", 1, 32'd256);
        check_csr("ptrs_after_reset", 3, m_ptrs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
